// File: rtl/pong_pkg.sv
// Shared pong definitions: tx FSM states, packet constants, who_won encoding and the snapshot layout.
package pong_pkg;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    typedef enum logic [1:0] {
        WON_NONE = 2'd0,
        WON_P2   = 2'd1,
        WON_P1   = 2'd2
    } who_won_t;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;
    localparam int         PKT_LEN_BASE   = 7;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [3:0]  p1;
        logic [3:0]  p2;
        who_won_t    won;
    } snap_t;

endpackage

// File: rtl/game_state_tx_if.sv
// Byte stream from the packetiser to the UART transmitter; a byte moves when tx_valid && tx_ready.
interface game_state_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/game_tx_checksum.sv
// Running XOR of accepted packet bytes; cleared at packet start. Only built with GAME_TX_CHECKSUM_EN.
`ifdef GAME_TX_CHECKSUM_EN
module game_tx_checksum (
    input  logic       clk65MHz,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_accept,
    input  logic [7:0] i_data,
    output logic [7:0] o_xor
);
    logic [7:0] r_acc;

    always_ff @(posedge clk65MHz) begin
        if (rst || i_clear) begin
            r_acc <= 8'h00;
        end else if (i_accept) begin
            r_acc <= r_acc ^ i_data;
        end
    end

    assign o_xor = r_acc;
endmodule
`endif

// File: rtl/game_state_tx.sv
// Snapshots game state every FRAME_DIV frame ticks and streams it as a byte packet (checksum byte with GAME_TX_CHECKSUM_EN).
// First byte valid one cycle after the trigger; bytes hold while tx_ready is low; frame ticks during a packet are dropped (overrun).
module game_state_tx
    import pong_pkg::*;
#(
    parameter logic [7:0]  HEADER_BYTE = DEFAULT_HEADER,
    parameter int unsigned FRAME_DIV   = 1
) (
    input  logic            clk65MHz,
    input  logic            rst,
    input  logic            end_of_frame,
    input  logic [10:0]     x_pos_of_ball,
    input  logic [10:0]     y_pos_of_ball,
    input  logic [3:0]      points_player_1,
    input  logic [3:0]      points_player_2,
    input  logic [1:0]      who_won,
    game_state_tx_if.master tx,
    output logic            busy,
    output logic            frame_sent,
    output logic            overrun
);
`ifdef GAME_TX_CHECKSUM_EN
    localparam int PKT_LEN = PKT_LEN_BASE + 1;
`else
    localparam int PKT_LEN = PKT_LEN_BASE;
`endif
    localparam logic [2:0] LAST_IDX = 3'(PKT_LEN - 1);
    localparam logic [3:0] DIV_LAST = 4'(FRAME_DIV - 1);

    tx_state_t  r_state;
    tx_state_t  w_state_nxt;
    logic [3:0] r_div;
    logic [2:0] r_idx;
    snap_t      r_snap;
    logic       r_frame_sent;
    logic       r_overrun;
    logic       w_trigger;
    logic       w_xfer;
    logic       w_last;
    logic [7:0] w_byte;

    assign w_trigger = (r_state == TX_IDLE) && end_of_frame && (r_div == DIV_LAST);
    assign w_xfer    = tx.tx_valid && tx.tx_ready;
    assign w_last    = w_xfer && (r_idx == LAST_IDX);

    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            r_state <= TX_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            TX_IDLE: if (w_trigger) w_state_nxt = TX_SEND;
            TX_SEND: if (w_last)    w_state_nxt = TX_IDLE;
            default:                w_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            r_div        <= 4'd0;
            r_idx        <= 3'd0;
            r_snap       <= '0;
            r_frame_sent <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_sent <= w_last;
            // Ticks arriving mid-packet are reported and never advance the divider.
            r_overrun    <= (r_state == TX_SEND) && end_of_frame;
            if ((r_state == TX_IDLE) && end_of_frame) begin
                r_div <= (r_div == DIV_LAST) ? 4'd0 : r_div + 4'd1;
            end
            if (w_trigger) begin
                r_snap <= '{x: x_pos_of_ball, y: y_pos_of_ball,
                            p1: points_player_1, p2: points_player_2,
                            won: who_won_t'(who_won)};
                r_idx  <= 3'd0;
            end else if (w_xfer) begin
                r_idx  <= w_last ? 3'd0 : r_idx + 3'd1;
            end
        end
    end

`ifdef GAME_TX_CHECKSUM_EN
    logic [7:0] w_csum;

    game_tx_checksum u_checksum (
        .clk65MHz (clk65MHz),
        .rst      (rst),
        .i_clear  (w_trigger),
        .i_accept (w_xfer && (r_idx != LAST_IDX)),
        .i_data   (w_byte),
        .o_xor    (w_csum)
    );
`endif

    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            3'd0:    w_byte = HEADER_BYTE;
            3'd1:    w_byte = {5'b0, r_snap.x[10:8]};
            3'd2:    w_byte = r_snap.x[7:0];
            3'd3:    w_byte = {5'b0, r_snap.y[10:8]};
            3'd4:    w_byte = r_snap.y[7:0];
            3'd5:    w_byte = {r_snap.p1, r_snap.p2};
            3'd6:    w_byte = {6'b0, r_snap.won};
`ifdef GAME_TX_CHECKSUM_EN
            3'd7:    w_byte = w_csum;
`endif
            default: w_byte = 8'h00;
        endcase
    end

    assign busy        = (r_state == TX_SEND);
    assign tx.tx_valid = busy;
    assign tx.tx_data  = busy ? w_byte : 8'h00;
    assign frame_sent  = r_frame_sent;
    assign overrun     = r_overrun;
endmodule

// File: tb/tb_game_state_tx.sv
// Bench for game_state_tx: scoreboard of expected packet bytes, plus a FRAME_DIV=3 instance for divider checks.
module tb_game_state_tx;
`ifdef GAME_TX_CHECKSUM_EN
    localparam int PKT_N = 8;
`else
    localparam int PKT_N = 7;
`endif

    logic        clk65MHz = 1'b0;
    logic        rst = 1'b1;
    logic        eof = 1'b0;
    logic        eof3 = 1'b0;
    logic [10:0] x = '0;
    logic [10:0] y = '0;
    logic [3:0]  p1 = '0;
    logic [3:0]  p2 = '0;
    logic [1:0]  ww = '0;
    logic        busy, fs, ov;
    logic        busy3, fs3, ov3;

    int          n_checks = 0;
    int          n_pass = 0;
    int          fs3_cnt = 0;
    int          bytes3 = 0;
    logic [7:0]  exp_q[$];

    game_state_tx_if tx_if ();
    game_state_tx_if tx_if3 ();

    game_state_tx #(.HEADER_BYTE(8'hA5), .FRAME_DIV(1)) dut (
        .clk65MHz(clk65MHz), .rst(rst), .end_of_frame(eof),
        .x_pos_of_ball(x), .y_pos_of_ball(y),
        .points_player_1(p1), .points_player_2(p2), .who_won(ww),
        .tx(tx_if), .busy(busy), .frame_sent(fs), .overrun(ov)
    );

    game_state_tx #(.HEADER_BYTE(8'hA5), .FRAME_DIV(3)) dut3 (
        .clk65MHz(clk65MHz), .rst(rst), .end_of_frame(eof3),
        .x_pos_of_ball(x), .y_pos_of_ball(y),
        .points_player_1(p1), .points_player_2(p2), .who_won(ww),
        .tx(tx_if3), .busy(busy3), .frame_sent(fs3), .overrun(ov3)
    );

    always #5 clk65MHz = ~clk65MHz;

    // Scoreboard: every accepted byte must match the head of the expected queue.
    always @(negedge clk65MHz) begin
        if (!rst && tx_if.tx_valid && tx_if.tx_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected_byte got=%h exp=<none>", tx_if.tx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (tx_if.tx_data !== e) $display("FAIL sb_byte got=%h exp=%h", tx_if.tx_data, e);
                else n_pass++;
            end
        end
        if (!rst && tx_if3.tx_valid && tx_if3.tx_ready) bytes3++;
        if (fs3) fs3_cnt++;
    end

    function automatic void push_pkt(input logic [10:0] xx, input logic [10:0] yy,
                                     input logic [3:0] a, input logic [3:0] b, input logic [1:0] w);
        logic [7:0] pb[8];
        pb[0] = 8'hA5;
        pb[1] = {5'b0, xx[10:8]};
        pb[2] = xx[7:0];
        pb[3] = {5'b0, yy[10:8]};
        pb[4] = yy[7:0];
        pb[5] = {a, b};
        pb[6] = {6'b0, w};
        pb[7] = 8'h00;
        for (int i = 0; i < 7; i++) pb[7] = pb[7] ^ pb[i];
        for (int i = 0; i < PKT_N; i++) exp_q.push_back(pb[i]);
    endfunction

    task automatic trigger();
        @(posedge clk65MHz); #1 eof = 1'b1;
        @(posedge clk65MHz); #1 eof = 1'b0;
        @(negedge clk65MHz);
    endtask

    // Counts valid cycles from the current negedge until frame_sent, bounded.
    task automatic wait_frame_sent(output int nv, output bit seen);
        nv = tx_if.tx_valid ? 1 : 0;
        seen = 1'b0;
        for (int c = 0; c < 80 && !seen; c++) begin
            @(negedge clk65MHz);
            if (fs) seen = 1'b1;
            else if (tx_if.tx_valid) nv++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tx_if.tx_ready = 1'b1;
        tx_if3.tx_ready = 1'b1;
        repeat (3) @(posedge clk65MHz);
        @(negedge clk65MHz);
        n_checks++; if (tx_if.tx_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", tx_if.tx_valid); else n_pass++;
        n_checks++; if (tx_if.tx_data !== 8'h00) $display("FAIL rst_data got=%h exp=00", tx_if.tx_data); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (fs !== 1'b0) $display("FAIL rst_frame_sent got=%b exp=0", fs); else n_pass++;
        n_checks++; if (ov !== 1'b0) $display("FAIL rst_overrun got=%b exp=0", ov); else n_pass++;
        @(posedge clk65MHz); #1 rst = 1'b0;
    endtask

    task automatic test_basic();
        int nv;
        bit seen;
        x = 11'd504; y = 11'd376; p1 = 4'd3; p2 = 4'd7; ww = 2'd0;
        tx_if.tx_ready = 1'b1;
        exp_q.push_back(8'hA5); exp_q.push_back(8'h01); exp_q.push_back(8'hF8);
        exp_q.push_back(8'h01); exp_q.push_back(8'h78); exp_q.push_back(8'h37);
        exp_q.push_back(8'h00);
`ifdef GAME_TX_CHECKSUM_EN
        exp_q.push_back(8'h12);
`endif
        @(posedge clk65MHz); #1 eof = 1'b1;
        @(negedge clk65MHz);
        n_checks++; if (tx_if.tx_valid !== 1'b0) $display("FAIL basic_valid_early got=%b exp=0", tx_if.tx_valid); else n_pass++;
        @(posedge clk65MHz); #1 eof = 1'b0;
        @(negedge clk65MHz);
        n_checks++; if (tx_if.tx_valid !== 1'b1) $display("FAIL basic_latency got=%b exp=1", tx_if.tx_valid); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy got=%b exp=1", busy); else n_pass++;
        wait_frame_sent(nv, seen);
        n_checks++; if (seen !== 1'b1) $display("FAIL basic_frame_sent got=%b exp=1", seen); else n_pass++;
        n_checks++; if (nv !== PKT_N) $display("FAIL basic_valid_cycles got=%0d exp=%0d", nv, PKT_N); else n_pass++;
        n_checks++; if (tx_if.tx_valid !== 1'b0) $display("FAIL basic_valid_after got=%b exp=0", tx_if.tx_valid); else n_pass++;
        n_checks++; if (exp_q.size() !== 0) $display("FAIL basic_queue_left got=%0d exp=0", exp_q.size()); else n_pass++;
        @(negedge clk65MHz);
        n_checks++; if (fs !== 1'b0) $display("FAIL basic_fs_pulse got=%b exp=0", fs); else n_pass++;
    endtask

    task automatic test_backpressure();
        int nv;
        bit seen;
        bit held;
        push_pkt(11'd504, 11'd376, 4'd3, 4'd7, 2'd0);
        trigger();
        @(posedge clk65MHz); #1;
        @(posedge clk65MHz); #1 tx_if.tx_ready = 1'b0;
        held = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk65MHz);
            if (tx_if.tx_data !== 8'hF8 || tx_if.tx_valid !== 1'b1) held = 1'b0;
        end
        n_checks++; if (held !== 1'b1) $display("FAIL bp_hold got=%h/%b exp=f8/1", tx_if.tx_data, tx_if.tx_valid); else n_pass++;
        @(posedge clk65MHz); #1 tx_if.tx_ready = 1'b1;
        wait_frame_sent(nv, seen);
        n_checks++; if (seen !== 1'b1) $display("FAIL bp_frame_sent got=%b exp=1", seen); else n_pass++;
        n_checks++; if (exp_q.size() !== 0) $display("FAIL bp_queue_left got=%0d exp=0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_overrun();
        int nv;
        bit seen;
        bit extra;
        x = 11'd504;
        push_pkt(11'd504, 11'd376, 4'd3, 4'd7, 2'd0);
        trigger();
        @(posedge clk65MHz); #1 x = 11'd100; eof = 1'b1;
        @(posedge clk65MHz); #1 eof = 1'b0;
        @(negedge clk65MHz);
        n_checks++; if (ov !== 1'b1) $display("FAIL ovr_pulse got=%b exp=1", ov); else n_pass++;
        @(negedge clk65MHz);
        n_checks++; if (ov !== 1'b0) $display("FAIL ovr_one_cycle got=%b exp=0", ov); else n_pass++;
        wait_frame_sent(nv, seen);
        n_checks++; if (seen !== 1'b1) $display("FAIL ovr_frame_sent got=%b exp=1", seen); else n_pass++;
        n_checks++; if (exp_q.size() !== 0) $display("FAIL ovr_queue_left got=%0d exp=0", exp_q.size()); else n_pass++;
        extra = 1'b0;
        repeat (5) begin
            @(negedge clk65MHz);
            if (busy !== 1'b0) extra = 1'b1;
        end
        n_checks++; if (extra !== 1'b0) $display("FAIL ovr_no_new_packet got=%b exp=0", extra); else n_pass++;
        x = 11'd504;
    endtask

    task automatic test_reset_mid();
        int nv;
        bit seen;
        push_pkt(11'd504, 11'd376, 4'd3, 4'd7, 2'd0);
        trigger();
        repeat (4) begin
            @(posedge clk65MHz); #1;
        end
        n_checks++; if (tx_if.tx_data !== 8'h78) $display("FAIL rmid_byte4 got=%h exp=78", tx_if.tx_data); else n_pass++;
        rst = 1'b1;
        @(posedge clk65MHz); #1 rst = 1'b0;
        @(negedge clk65MHz);
        n_checks++; if (tx_if.tx_valid !== 1'b0) $display("FAIL rmid_valid got=%b exp=0", tx_if.tx_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (exp_q.size() !== PKT_N - 4) $display("FAIL rmid_sent_bytes got=%0d exp=%0d", exp_q.size(), PKT_N - 4); else n_pass++;
        exp_q.delete();
        x = 11'd1023; y = 11'd5; p1 = 4'd15; p2 = 4'd0; ww = 2'd2;
        push_pkt(11'd1023, 11'd5, 4'd15, 4'd0, 2'd2);
        trigger();
        n_checks++; if (tx_if.tx_data !== 8'hA5) $display("FAIL rmid_header got=%h exp=a5", tx_if.tx_data); else n_pass++;
        wait_frame_sent(nv, seen);
        n_checks++; if (seen !== 1'b1) $display("FAIL rmid_frame_sent got=%b exp=1", seen); else n_pass++;
        n_checks++; if (nv !== PKT_N) $display("FAIL rmid_valid_cycles got=%0d exp=%0d", nv, PKT_N); else n_pass++;
        n_checks++; if (exp_q.size() !== 0) $display("FAIL rmid_queue_left got=%0d exp=0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_frame_div();
        int fs_before;
        int b_before;
        fs_before = fs3_cnt;
        b_before = bytes3;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk65MHz); #1 eof3 = 1'b1;
            @(posedge clk65MHz); #1 eof3 = 1'b0;
            @(negedge clk65MHz);
            n_checks++;
            if (busy3 !== ((k % 3) == 0)) $display("FAIL div_pulse%0d got=%b exp=%b", k, busy3, ((k % 3) == 0));
            else n_pass++;
            repeat (198) @(posedge clk65MHz);
        end
        n_checks++; if (fs3_cnt - fs_before !== 2) $display("FAIL div_packets got=%0d exp=2", fs3_cnt - fs_before); else n_pass++;
        n_checks++; if (bytes3 - b_before !== 2 * PKT_N) $display("FAIL div_bytes got=%0d exp=%0d", bytes3 - b_before, 2 * PKT_N); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overrun();
        test_reset_mid();
        test_frame_div();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/game_state_tx.md
GAME_STATE_TX -- requirements
Module: game_state_tx

Interface
REQ-001 SHALL have parameter HEADER_BYTE, default 8'hA5, the first byte of every packet.
REQ-002 SHALL have parameter FRAME_DIV, default 1 (range 1..15): one packet is sent per FRAME_DIV accepted end_of_frame pulses.
REQ-003 SHALL have clk65MHz, input, 1: the single clock; rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have end_of_frame, input, 1: one-cycle frame tick.
REQ-005 SHALL have x_pos_of_ball and y_pos_of_ball, input, 11 each: ball position.
REQ-006 SHALL have points_player_1 and points_player_2, input, 4 each: scores.
REQ-007 SHALL have who_won, input, 2: 0 = none, 1 = player 2, 2 = player 1.
REQ-008 SHALL have tx_ready, input, 1: the downstream UART transmitter accepts a byte.
REQ-009 SHALL have tx_data, output, 8, and tx_valid, output, 1: the byte stream.
REQ-010 SHALL have busy, output, 1 (packet in progress), frame_sent, output, 1 (one-cycle pulse per completed packet) and overrun, output, 1 (one-cycle pulse per dropped trigger).

Function
REQ-011 SHALL implement states IDLE and SEND only.
REQ-012 SHALL count end_of_frame pulses seen in IDLE with a 4-bit divider counter; the trigger is the pulse on which counter == FRAME_DIV-1, and the counter then wraps to 0.
REQ-013 On trigger, SHALL capture all game inputs into a snapshot register in the same cycle, enter SEND with byte index 0, and assert tx_valid on the next cycle (latency 1).
REQ-014 Packet byte order SHALL be: HEADER_BYTE, {5'b0,x[10:8]}, x[7:0], {5'b0,y[10:8]}, y[7:0], {points_player_1,points_player_2}, {6'b0,who_won}, then the optional checksum.
REQ-015 A byte SHALL transfer on a cycle where tx_valid && tx_ready; the index then increments in the same edge.
REQ-016 tx_data SHALL hold stable while tx_valid && !tx_ready, and tx_valid SHALL NOT deassert before the transfer.
REQ-017 After the last byte transfers, SHALL return to IDLE, deassert tx_valid, and pulse frame_sent for one cycle on the following cycle.
REQ-018 An end_of_frame in SEND SHALL be ignored by the divider and pulse overrun; the snapshot SHALL stay unchanged.
REQ-019 Input changes during SEND SHALL NOT affect bytes already captured.
REQ-020 busy SHALL equal (state == SEND).
REQ-021 With tx_ready tied high, a packet SHALL occupy exactly N consecutive tx_valid cycles, where N is the packet length in bytes.

Reset
REQ-022 When rst is sampled high, the next edge SHALL force IDLE, divider 0, index 0, snapshot 0, tx_data 8'h00, and tx_valid, busy, frame_sent and overrun all 0, including in the middle of a packet.
REQ-023 No partial packet SHALL resume after reset; the next packet starts from the header.

Configuration
REQ-024 Macro GAME_TX_CHECKSUM_EN defined: SHALL append byte 7, the XOR of bytes 0..6, for N = 8.
REQ-025 Macro GAME_TX_CHECKSUM_EN undefined: SHALL omit the checksum, for N = 7, and synthesize no checksum logic.

Structure
REQ-026 A shared package pong_pkg SHALL hold the tx state enum, the default header 8'hA5, the constant PKT_LEN_BASE = 7, and the who_won encoding.
REQ-027 The checksum accumulator SHALL be the sub-module game_tx_checksum (clear, byte-accept strobe, data in, 8-bit XOR out), instantiated only under GAME_TX_CHECKSUM_EN.

Verification
REQ-028 x=504, y=376, p1=3, p2=7, who_won=0, tx_ready=1, one end_of_frame, macro on -> bytes A5 01 F8 01 78 37 00 12, then one frame_sent pulse.
REQ-029 Same stimulus with the macro off -> bytes A5 01 F8 01 78 37 00, 7 valid cycles, then frame_sent.
REQ-030 tx_ready low for 5 cycles at byte 2 -> tx_data held at F8 with tx_valid high throughout, and packet contents unchanged.
REQ-031 FRAME_DIV=3, 6 end_of_frame pulses spaced 200 cycles apart -> exactly 2 packets, triggered on pulses 3 and 6.
REQ-032 end_of_frame during SEND, with x changed to 100 mid-packet -> one overrun pulse, and the current packet still carries x=504.
REQ-033 rst asserted while sending byte 4 -> tx_valid 0 on the next edge; the next trigger yields a packet starting with A5.
